ftm_recovery_ctrl: RTL and testbench
====================================

// Module: ftm_recovery_ctrl
// PURPOSE
//   Lockstep supervisor and rollback sequencer for the dual-core FT SoC. Sits between core_0/core_1 and the data memory.
//   Compares per-cycle retire/store activity of both cores and gates stores to data_mem while they disagree.
//   On a mismatch it halts fetch, drains, and restores both cores to the last agreed PC.
//   Escalates to a sticky FAIL after repeated back-to-back errors.
// PARAMETERS
//   BOOT_ADDR     32'h0000_0080  initial checkpoint PC after reset
//   DRAIN_CYCLES  4              cycles fetch is held low before restore (pipeline drain), >=1
//   RETRY_WINDOW  64             cycles after restore in which a new error counts as a retry
//   MAX_RETRY     3              consecutive retries before FAIL, >=1
//   CNT_W         8              width of error counter
// PORTS
//   clk_i           in   1      clock
//   rst_ni          in   1      asynchronous active-low reset
//   fetch_enable_i  in   1      SoC-level run request
//   c0_valid_i      in   1      core_0 retires an instruction this cycle
//   c1_valid_i      in   1      core_1 retires an instruction this cycle
//   c0_pc_i         in   32     core_0 retired PC
//   c1_pc_i         in   32     core_1 retired PC
//   c0_we_i         in   1      core_0 data store request
//   c1_we_i         in   1      core_1 data store request
//   c0_addr_i       in   32     core_0 store address
//   c1_addr_i       in   32     core_1 store address
//   c0_wdata_i      in   32     core_0 store data
//   c1_wdata_i      in   32     core_1 store data
//   mem_we_o        out  1      gated store enable to data_mem
//   fetch_enable_o  out  1      fetch enable to both cores
//   restore_o       out  1      1-cycle pulse: load restore_pc_o into both cores
//   restore_pc_o    out  32     checkpoint PC
//   error_o         out  1      1-cycle pulse per detected mismatch
//   fail_o          out  1      sticky unrecoverable flag
//   error_count_o   out  CNT_W  saturating count of detected mismatches
//   state_o         out  3      current FSM state (debug)
// BEHAVIOUR
//   Reset: state IDLE; fetch_enable_o=0, restore_o=0, error_o=0, fail_o=0, mem_we_o=0,
//     error_count_o=0, restore_pc_o=BOOT_ADDR, drain/window/retry counters=0.
//   mismatch (combinational, evaluated only in RUN):
//     c0_valid_i!=c1_valid_i | (c0_valid_i & c0_pc_i!=c1_pc_i) | c0_we_i!=c1_we_i |
//     (c0_we_i & (c0_addr_i!=c1_addr_i | c0_wdata_i!=c1_wdata_i)).
//   mem_we_o = (state==RUN) & c0_we_i & ~mismatch. Combinational, same cycle; a corrupt store never reaches memory.
//   Checkpoint: in RUN, when c0_valid_i & c1_valid_i & ~mismatch, restore_pc_o <= c0_pc_i.
//   FSM (registered):
//     IDLE: fetch_enable_o=0. fetch_enable_i=1 -> RUN.
//     RUN: fetch_enable_o=1.
//       If mismatch: error_o=1 next cycle, error_count+1 (saturate at all-ones), next state HALT.
//       If window>0 at that point, retry+1, else retry=1.
//       If retry would reach MAX_RETRY, go to FAIL instead of HALT.
//       If fetch_enable_i=0 and no mismatch -> IDLE.
//     HALT: fetch_enable_o=0; count DRAIN_CYCLES cycles -> RESTORE.
//     RESTORE: restore_o=1 for exactly one cycle, window<=RETRY_WINDOW.
//       Next state RUN if fetch_enable_i, else IDLE.
//     FAIL: fetch_enable_o=0, fail_o=1; exits only on reset.
//   Window counter decrements in RUN while >0. When it reaches 0 with no error, retry<=0.
//   Detection-to-restore latency: mismatch in cycle N -> HALT at N+1 -> restore_o at N+1+DRAIN_CYCLES.
//   Mismatches outside RUN are ignored: no error_o, no count, no checkpoint.
//   fetch_enable_i dropped during HALT/RESTORE: recovery completes, then IDLE.
//   Asynchronous reset mid-recovery returns to reset values immediately; fail_o cleared.
//   state_o encoding: IDLE=0, RUN=1, HALT=2, RESTORE=3, FAIL=4.
// STRUCTURE
//   cevero_ft_pkg: ftm_state_e enum (3-bit, encoding above); lockstep_port_t struct {valid,pc,we,addr,wdata}.
//   Sub-module ftm_lockstep_cmp: pure comparator, two lockstep_port_t in -> mismatch out.
//   Top holds the FSM, counters and checkpoint register.
// TESTING
//   Identical streams, 1000 cycles, including stores -> error_o never 1, mem_we_o==c0_we_i, restore_pc_o tracks last pc.
//   c1_wdata_i flipped on a store at cycle 200 -> mem_we_o=0 that cycle; error_o at 201; fetch_enable_o low 201..204;
//     restore_o=1 at 205 with restore_pc_o = last agreed PC.
//   c1_valid_i=0 while c0_valid_i=1 in RUN -> single error, error_count_o=1, state back to RUN after restore.
//   Three mismatches each within 64 cycles of previous restore (MAX_RETRY=3) -> third goes to FAIL;
//     fail_o=1, fetch_enable_o=0 held 100 cycles, restore_o not pulsed.
//   Two mismatches 100 cycles apart -> retry resets, no FAIL; error_count_o=2.
//   rst_ni low during HALT -> all outputs at reset values next edge; CNT_W=2 with 5 errors -> error_count_o saturates at 3.

Source files
------------

// File: rtl/cevero_ft_pkg.sv
// Purpose: shared types for the lockstep supervisor (FSM states, per-core port bundle).
// Latency: n/a (types only).
// Backpressure: n/a.
package cevero_ft_pkg;

  // Values are visible on state_o, so the numbering is fixed.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_HALT    = 3'd2,
    ST_RESTORE = 3'd3,
    ST_FAIL    = 3'd4
  } ftm_state_e;

  // Retire and store activity of one core in one cycle.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lockstep_port_t;

endpackage

// File: rtl/ftm_lockstep_cmp.sv
// Purpose: flags any observable disagreement between the two lockstep cores.
// Latency: combinational, same cycle.
// Backpressure: none; evaluated every cycle.
module ftm_lockstep_cmp
  import cevero_ft_pkg::*;
(
  input  lockstep_port_t a_i,
  input  lockstep_port_t b_i,
  output logic           mismatch_o
);

  // PC is only meaningful when retiring; address/data only when storing.
  always_comb begin
    mismatch_o = (a_i.valid != b_i.valid)
               | (a_i.valid & (a_i.pc != b_i.pc))
               | (a_i.we != b_i.we)
               | (a_i.we & ((a_i.addr != b_i.addr) | (a_i.wdata != b_i.wdata)));
  end

endmodule

// File: rtl/ftm_recovery_ctrl.sv
// Purpose: lockstep supervisor; gates stores, halts/drains/rolls back on mismatch, sticky FAIL.
// Latency: mem_we same cycle; error_o 1 cycle after mismatch; restore_o 1+DRAIN_CYCLES after.
// Backpressure: none; fetch_enable_o is the only throttle and drops during recovery.
module ftm_recovery_ctrl
  import cevero_ft_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR    = 32'h0000_0080,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned RETRY_WINDOW = 64,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             fetch_enable_i,
  input  logic             c0_valid_i,
  input  logic             c1_valid_i,
  input  logic [31:0]      c0_pc_i,
  input  logic [31:0]      c1_pc_i,
  input  logic             c0_we_i,
  input  logic             c1_we_i,
  input  logic [31:0]      c0_addr_i,
  input  logic [31:0]      c1_addr_i,
  input  logic [31:0]      c0_wdata_i,
  input  logic [31:0]      c1_wdata_i,
  output logic             mem_we_o,
  output logic             fetch_enable_o,
  output logic             restore_o,
  output logic [31:0]      restore_pc_o,
  output logic             error_o,
  output logic             fail_o,
  output logic [CNT_W-1:0] error_count_o,
  output logic [2:0]       state_o
);

  localparam int unsigned DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int unsigned WIN_W = (RETRY_WINDOW > 0) ? $clog2(RETRY_WINDOW + 1) : 1;
  localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1);

  ftm_state_e       state_q, state_d;
  logic [DRN_W-1:0] drain_q, drain_d;
  logic [WIN_W-1:0] window_q, window_d;
  logic [RTY_W-1:0] retry_q, retry_d, retry_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      ckpt_q, ckpt_d;
  logic             err_q, err_d;

  lockstep_port_t   port0, port1;
  logic             mismatch;
  logic             in_run;

  assign port0 = '{valid: c0_valid_i, pc: c0_pc_i, we: c0_we_i, addr: c0_addr_i, wdata: c0_wdata_i};
  assign port1 = '{valid: c1_valid_i, pc: c1_pc_i, we: c1_we_i, addr: c1_addr_i, wdata: c1_wdata_i};

  ftm_lockstep_cmp u_cmp (
    .a_i        (port0),
    .b_i        (port1),
    .mismatch_o (mismatch)
  );

  assign in_run = (state_q == ST_RUN);

  // A disagreeing store is dropped in the same cycle it is presented.
  assign mem_we_o       = in_run & c0_we_i & ~mismatch;
  assign fetch_enable_o = in_run;
  assign restore_o      = (state_q == ST_RESTORE);
  assign fail_o         = (state_q == ST_FAIL);
  assign restore_pc_o   = ckpt_q;
  assign error_o        = err_q;
  assign error_count_o  = cnt_q;
  assign state_o        = state_q;

  // An error inside the post-restore window extends the retry streak; otherwise it starts a new one.
  assign retry_inc = (window_q != '0) ? retry_q + RTY_W'(1) : RTY_W'(1);

  // Next-state, counters and checkpoint update.
  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    window_d = window_q;
    retry_d  = retry_q;
    cnt_d    = cnt_q;
    ckpt_d   = ckpt_q;
    err_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fetch_enable_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (mismatch) begin
          err_d   = 1'b1;
          drain_d = '0;
          retry_d = retry_inc;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          state_d = (retry_inc >= RTY_W'(MAX_RETRY)) ? ST_FAIL : ST_HALT;
        end else begin
          if (c0_valid_i & c1_valid_i) ckpt_d = c0_pc_i;
          if (window_q != '0) begin
            window_d = window_q - WIN_W'(1);
            // Window ran out cleanly: the error streak is over.
            if (window_q == WIN_W'(1)) retry_d = '0;
          end
          if (!fetch_enable_i) state_d = ST_IDLE;
        end
      end
      ST_HALT: begin
        if (drain_q == DRN_W'(DRAIN_CYCLES - 1)) state_d = ST_RESTORE;
        else                                      drain_d = drain_q + DRN_W'(1);
      end
      ST_RESTORE: begin
        window_d = WIN_W'(RETRY_WINDOW);
        state_d  = fetch_enable_i ? ST_RUN : ST_IDLE;
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers; reset returns to boot checkpoint with a clean history.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      drain_q  <= '0;
      window_q <= '0;
      retry_q  <= '0;
      cnt_q    <= '0;
      ckpt_q   <= BOOT_ADDR;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      window_q <= window_d;
      retry_q  <= retry_d;
      cnt_q    <= cnt_d;
      ckpt_q   <= ckpt_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_ftm_recovery_ctrl.sv
// Purpose: scoreboard bench for ftm_recovery_ctrl against a timeline-based reference model.
// Latency: expected values queued at drive time, checked on the following falling edge.
// Backpressure: n/a.
module tb_ftm_recovery_ctrl;
  import cevero_ft_pkg::*;

  localparam logic [31:0] BOOT  = 32'h0000_0080;
  localparam int          DRAIN = 4;
  localparam int          WIN   = 64;
  localparam int          MAXR  = 3;
  localparam int          CW    = 2;
  localparam int          CMAX  = (1 << CW) - 1;

  localparam int P_IDLE = 0, P_RUN = 1, P_HALT = 2, P_RST = 3, P_FAIL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic fe = 1'b0;
  lockstep_port_t p0 = '0, p1 = '0;

  logic          mem_we_o, fetch_enable_o, restore_o, error_o, fail_o;
  logic [31:0]   restore_pc_o;
  logic [CW-1:0] error_count_o;
  logic [2:0]    state_o;

  ftm_recovery_ctrl #(
    .BOOT_ADDR(BOOT), .DRAIN_CYCLES(DRAIN), .RETRY_WINDOW(WIN), .MAX_RETRY(MAXR), .CNT_W(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .fetch_enable_i(fe),
    .c0_valid_i(p0.valid), .c1_valid_i(p1.valid),
    .c0_pc_i(p0.pc), .c1_pc_i(p1.pc),
    .c0_we_i(p0.we), .c1_we_i(p1.we),
    .c0_addr_i(p0.addr), .c1_addr_i(p1.addr),
    .c0_wdata_i(p0.wdata), .c1_wdata_i(p1.wdata),
    .mem_we_o(mem_we_o), .fetch_enable_o(fetch_enable_o), .restore_o(restore_o),
    .restore_pc_o(restore_pc_o), .error_o(error_o), .fail_o(fail_o),
    .error_count_o(error_count_o), .state_o(state_o)
  );

  typedef struct {
    logic        mem_we, fen, rst, err, fail;
    logic [31:0] rpc;
    logic [31:0] cnt;
    logic [31:0] st;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference model: a timeline of phases with absolute cycle stamps.
  int          m_cyc = 0;
  int          m_phase, m_restore_at, m_runs, m_retry, m_cnt;
  logic [31:0] m_ckpt;
  logic        m_errp;

  function automatic void model_reset();
    m_phase = P_IDLE; m_restore_at = -1; m_runs = WIN; m_retry = 0;
    m_cnt = 0; m_ckpt = BOOT; m_errp = 1'b0;
  endfunction

  function automatic logic cores_disagree(lockstep_port_t a, lockstep_port_t b);
    if (a.valid != b.valid) return 1'b1;
    if (a.valid && a.pc != b.pc) return 1'b1;
    if (a.we != b.we) return 1'b1;
    if (a.we && (a.addr != b.addr || a.wdata != b.wdata)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t model_outputs(lockstep_port_t a, lockstep_port_t b);
    exp_t e;
    e.fen    = (m_phase == P_RUN);
    e.rst    = (m_phase == P_RST);
    e.fail   = (m_phase == P_FAIL);
    e.err    = m_errp;
    e.rpc    = m_ckpt;
    e.cnt    = m_cnt;
    e.st     = m_phase;
    e.mem_we = (m_phase == P_RUN) && a.we && !cores_disagree(a, b);
    return e;
  endfunction

  function automatic void model_advance(lockstep_port_t a, lockstep_port_t b, logic fe_v);
    logic bad;
    bad    = cores_disagree(a, b);
    m_errp = 1'b0;
    case (m_phase)
      P_IDLE: if (fe_v) m_phase = P_RUN;
      P_RUN: begin
        if (bad) begin
          m_errp = 1'b1;
          if (m_cnt < CMAX) m_cnt++;
          m_retry = (m_runs < WIN) ? m_retry + 1 : 1;
          if (m_retry >= MAXR) m_phase = P_FAIL;
          else begin
            m_phase      = P_HALT;
            m_restore_at = m_cyc + 1 + DRAIN;
          end
        end else begin
          if (a.valid) m_ckpt = a.pc;
          m_runs++;
          if (!fe_v) m_phase = P_IDLE;
        end
      end
      P_HALT: if (m_cyc + 1 == m_restore_at) m_phase = P_RST;
      P_RST: begin
        m_runs  = 0;
        m_phase = fe_v ? P_RUN : P_IDLE;
      end
      default: ;
    endcase
  endfunction

  // Drive one cycle just after the rising edge and queue what the DUT must show for it.
  task automatic step(input lockstep_port_t a, input lockstep_port_t b, input logic fe_v, input logic rst_v);
    @(posedge clk);
    #1;
    p0 = a; p1 = b; fe = fe_v; rst_n = rst_v;
    m_cyc++;
    if (!rst_v) model_reset();
    exp_q.push_back(model_outputs(a, b));
    if (rst_v) model_advance(a, b, fe_v);
  endtask

  // Agreeing cores; fields that don't matter (pc when idle, addr/data without store) may differ.
  task automatic gen_good(output lockstep_port_t a, output lockstep_port_t b);
    a.valid = ($urandom_range(0, 3) != 0);
    a.pc    = $urandom() & 32'hFFFF_FFFC;
    a.we    = ($urandom_range(0, 2) == 0);
    a.addr  = $urandom();
    a.wdata = $urandom();
    b = a;
    if (!a.valid) b.pc = $urandom();
    if (!a.we) begin
      b.addr  = $urandom();
      b.wdata = $urandom();
    end
  endtask

  task automatic gen_bad(input int kind, output lockstep_port_t a, output lockstep_port_t b);
    gen_good(a, b);
    case (kind)
      0: b.valid = ~a.valid;
      1: begin a.valid = 1'b1; b = a; b.pc = a.pc ^ 32'h4; end
      2: b.we = ~a.we;
      3: begin a.we = 1'b1; b = a; b.addr = a.addr ^ 32'h1; end
      default: begin a.we = 1'b1; b = a; b.wdata = a.wdata ^ (32'h1 << $urandom_range(0, 31)); end
    endcase
  endtask

  task automatic good(input int n, input logic fe_v);
    lockstep_port_t a, b;
    for (int i = 0; i < n; i++) begin
      gen_good(a, b);
      step(a, b, fe_v, 1'b1);
    end
  endtask

  task automatic bad(input int kind, input logic fe_v);
    lockstep_port_t a, b;
    gen_bad(kind, a, b);
    step(a, b, fe_v, 1'b1);
  endtask

  task automatic do_reset(input int n);
    lockstep_port_t a, b;
    for (int i = 0; i < n; i++) begin
      gen_bad($urandom_range(0, 4), a, b);
      step(a, b, 1'b1, 1'b0);
    end
  endtask

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] want);
    if (act !== want) begin
      n_miss++;
      $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, act, want);
    end
  endfunction

  // Monitor: every falling edge the DUT presents a full output vector.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_vec++;
      chk("mem_we",      {31'b0, mem_we_o},       {31'b0, mon_e.mem_we});
      chk("fetch_en",    {31'b0, fetch_enable_o}, {31'b0, mon_e.fen});
      chk("restore",     {31'b0, restore_o},      {31'b0, mon_e.rst});
      chk("error",       {31'b0, error_o},        {31'b0, mon_e.err});
      chk("fail",        {31'b0, fail_o},         {31'b0, mon_e.fail});
      chk("restore_pc",  restore_pc_o,            mon_e.rpc);
      chk("error_count", {30'b0, error_count_o},  mon_e.cnt);
      chk("state",       {29'b0, state_o},        mon_e.st);
    end
  end

  initial begin
    logic fe_r;
    model_reset();
    do_reset(3);
    good(5, 1'b0);                         // released but idle: no fetch, no stores
    // Agreeing stream with one corrupted store on its 200th cycle.
    good(199, 1'b1);
    bad(4, 1'b1);
    good(800, 1'b1);
    // Single valid disagreement, recovers to RUN.
    bad(0, 1'b1);
    good(20, 1'b1);
    // Three errors each inside the retry window: the third is fatal.
    do_reset(2);
    good(3, 1'b1);
    bad(1, 1'b1); good(10, 1'b1);
    bad(2, 1'b1); good(10, 1'b1);
    bad(3, 1'b1);
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 3) == 0) bad($urandom_range(0, 4), 1'b1);
      else good(1, 1'b1);
    end
    // Two errors far apart: streak resets, no FAIL.
    do_reset(2);
    good(3, 1'b1);
    bad(4, 1'b1); good(100, 1'b1);
    bad(0, 1'b1); good(20, 1'b1);
    // Run request withdrawn mid-recovery.
    bad(1, 1'b1); good(2, 1'b1); good(10, 1'b0); good(3, 1'b1);
    // Reset asserted while halted.
    bad(2, 1'b1); good(2, 1'b1); do_reset(2); good(3, 1'b1);
    // Five spaced errors saturate the 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      bad(i, 1'b1);
      good(80, 1'b1);
    end
    // Random soak with sparse errors, run-request toggles and resets.
    do_reset(1);
    fe_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) fe_r = ~fe_r;
      if ($urandom_range(0, 1499) == 0) do_reset(1);
      else if ($urandom_range(0, 39) == 0) bad($urandom_range(0, 4), fe_r);
      else good(1, fe_r);
    end
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d vectors left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
